// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer over one shared Montgomery multiplier.
// Latency ops*(L+1)+EXP_WIDTH+1 from accepted start to done_out; start_in is ignored while busy.
module mont_modexp_ctrl #(
   parameter int WIDTH     = 512,
   parameter int EXP_WIDTH = 512
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 start_in,
   input  logic [WIDTH-1:0]     base_in,
   input  logic [EXP_WIDTH-1:0] exp_in,
   input  logic [WIDTH-1:0]     r2_in,
   output logic                 mul_start_out,
   output logic [WIDTH-1:0]     mul_a_out,
   output logic [WIDTH-1:0]     mul_b_out,
   input  logic                 mul_done_in,
   input  logic [WIDTH-1:0]     mul_result_in,
   output logic [WIDTH-1:0]     result_out,
   output logic                 done_out,
   output logic                 busy_out
);

   localparam int CW = $clog2(EXP_WIDTH + 1);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV_BASE,
      S_CONV_ONE,
      S_SQUARE,
      S_MULT,
      S_NEXT,
      S_CONV_OUT,
      S_DONE
   } state_t;

   state_t               state_q, state_d, op_next;
   logic                 wait_q, wait_d;
   logic [WIDTH-1:0]     base_q, base_d;
   logic [WIDTH-1:0]     base_m_q, base_m_d;
   logic [WIDTH-1:0]     acc_q, acc_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic [EXP_WIDTH-1:0] exp_q, exp_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 op_state;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q  <= S_IDLE;
         wait_q   <= 1'b0;
         base_q   <= '0;
         base_m_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         exp_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         base_q   <= base_d;
         base_m_q <= base_m_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         exp_q    <= exp_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      base_d        = base_q;
      base_m_d      = base_m_q;
      acc_d         = acc_q;
      result_d      = result_q;
      exp_d         = exp_q;
      cnt_d         = cnt_q;
      op_next       = state_q;
      op_state      = 1'b0;
      mul_start_out = 1'b0;
      mul_a_out     = '0;
      mul_b_out     = '0;

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               base_d  = base_in;
               exp_d   = exp_in;
               cnt_d   = CW'(EXP_WIDTH);
               wait_d  = 1'b0;
               state_d = S_CONV_BASE;
            end
         end
         S_CONV_BASE: begin
            op_state  = 1'b1;
            mul_a_out = base_q;
            mul_b_out = r2_in;
            op_next   = S_CONV_ONE;
         end
         S_CONV_ONE: begin
            // 1 * R^2 * R^-1 seeds the accumulator with R mod N
            op_state  = 1'b1;
            mul_a_out = ONE;
            mul_b_out = r2_in;
            op_next   = S_SQUARE;
         end
         S_SQUARE: begin
            op_state  = 1'b1;
            mul_a_out = acc_q;
            mul_b_out = acc_q;
            op_next   = exp_q[EXP_WIDTH-1] ? S_MULT : S_NEXT;
         end
         S_MULT: begin
            op_state  = 1'b1;
            mul_a_out = acc_q;
            mul_b_out = base_m_q;
            op_next   = S_NEXT;
         end
         S_NEXT: begin
            exp_d   = exp_q << 1;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? S_CONV_OUT : S_SQUARE;
         end
         S_CONV_OUT: begin
            op_state  = 1'b1;
            mul_a_out = acc_q;
            mul_b_out = ONE;
            op_next   = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Shared issue/wait handling; a done pulse during the issue cycle is not a completion
      if (op_state) begin
         if (!wait_q) begin
            mul_start_out = 1'b1;
            wait_d        = 1'b1;
         end else if (mul_done_in) begin
            wait_d  = 1'b0;
            state_d = op_next;
            case (state_q)
               S_CONV_BASE: base_m_d = mul_result_in;
               S_CONV_OUT:  result_d = mul_result_in;
               default:     acc_d    = mul_result_in;
            endcase
         end
      end
   end

   assign result_out = result_q;
   assign done_out   = (state_q == S_DONE);
   assign busy_out   = (state_q != S_IDLE);

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Directed bench for mont_modexp_ctrl with N=13, R=256, r2=3 and a behavioural multiplier.
// mont(a,b) = a*b*R^-1 mod 13 = a*b*3 mod 13, since 256*3 = 768 = 1 mod 13.
module tb_mont_modexp_ctrl;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic       start_in = 1'b0;
   logic [7:0] base_in = '0;
   logic [7:0] exp_in = '0;
   logic [7:0] r2_in = 8'd3;
   logic       mul_start_out;
   logic [7:0] mul_a_out, mul_b_out;
   logic       mul_done_in;
   logic [7:0] mul_result_in;
   logic [7:0] result_out;
   logic       done_out, busy_out;

   int errors = 0;
   int checks = 0;

   int         lat = 3;
   int         mcnt = 0;
   logic [7:0] ma_q = '0, mb_q = '0, mr_q = '0;
   logic       inj_done = 1'b0;
   int         starts_total = 0;
   int         dones_total = 0;
   int         unstable_total = 0;

   mont_modexp_ctrl #(.WIDTH(8), .EXP_WIDTH(8)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .base_in       (base_in),
      .exp_in        (exp_in),
      .r2_in         (r2_in),
      .mul_start_out (mul_start_out),
      .mul_a_out     (mul_a_out),
      .mul_b_out     (mul_b_out),
      .mul_done_in   (mul_done_in),
      .mul_result_in (mul_result_in),
      .result_out    (result_out),
      .done_out      (done_out),
      .busy_out      (busy_out)
   );

   always #5 clk_in = ~clk_in;

   assign mul_done_in   = (mcnt == 1) | inj_done;
   assign mul_result_in = inj_done ? 8'hA5 : mr_q;

   // Multiplier model: done arrives exactly lat cycles after the start pulse
   always @(posedge clk_in) begin
      if (mul_start_out) starts_total <= starts_total + 1;
      if (done_out) dones_total <= dones_total + 1;
      if (rst_in) begin
         mcnt <= 0;
      end else if (mul_start_out) begin
         ma_q <= mul_a_out;
         mb_q <= mul_b_out;
         mr_q <= 8'((int'(mul_a_out) * int'(mul_b_out) * 3) % 13);
         mcnt <= lat;
      end else if (mcnt != 0) begin
         if (mul_a_out !== ma_q || mul_b_out !== mb_q) unstable_total <= unstable_total + 1;
         mcnt <= mcnt - 1;
      end
   end

   task automatic run_op(input string nm, input logic [7:0] b, input logic [7:0] e,
                         input int l, input logic [7:0] res, input int ops,
                         input int cyc, input int poke_at);
      int n, s0, d0, u0;
      lat = l;
      s0 = starts_total;
      d0 = dones_total;
      u0 = unstable_total;
      base_in  = b;
      exp_in   = e;
      start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      n = 1;
      while (done_out !== 1'b1 && n < 2000) begin
         if (n == poke_at) begin
            start_in = 1'b1;
            base_in  = 8'd9;
            exp_in   = 8'd77;
         end
         @(posedge clk_in); #1;
         start_in = 1'b0;
         n++;
      end
      checks++;
      if (done_out !== 1'b1) begin
         errors++;
         $display("FAIL %s timeout: done_out=%b after %0d cycles, required 1", nm, done_out, n);
      end
      checks++;
      if (result_out !== res) begin
         errors++;
         $display("FAIL %s result: got %0d, required %0d", nm, result_out, res);
      end
      checks++;
      if (n != cyc) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles, required %0d", nm, n, cyc);
      end
      checks++;
      if (starts_total - s0 != ops) begin
         errors++;
         $display("FAIL %s op count: got %0d, required %0d", nm, starts_total - s0, ops);
      end
      checks++;
      if (busy_out !== 1'b1) begin
         errors++;
         $display("FAIL %s busy at done: got %b, required 1", nm, busy_out);
      end
      @(posedge clk_in); #1;
      checks++;
      if (done_out !== 1'b0 || dones_total - d0 != 1) begin
         errors++;
         $display("FAIL %s done width: done_out=%b pulses=%0d, required 0 and 1", nm, done_out,
                  dones_total - d0);
      end
      checks++;
      if (busy_out !== 1'b0) begin
         errors++;
         $display("FAIL %s busy after done: got %b, required 0", nm, busy_out);
      end
      checks++;
      if (unstable_total - u0 != 0) begin
         errors++;
         $display("FAIL %s operand stability: %0d unstable wait cycles, required 0", nm,
                  unstable_total - u0);
      end
   endtask

   task automatic check_idle_outputs(input string nm);
      checks++;
      if (mul_start_out !== 1'b0 || mul_a_out !== 8'd0 || mul_b_out !== 8'd0 ||
          result_out !== 8'd0 || done_out !== 1'b0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL %s: start=%b a=%0d b=%0d res=%0d done=%b busy=%b, required all 0", nm,
                  mul_start_out, mul_a_out, mul_b_out, result_out, done_out, busy_out);
      end
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
      check_idle_outputs("reset_state");
      rst_in = 1'b0;
      @(posedge clk_in); #1;
      check_idle_outputs("post_reset_idle");
   endtask

   // 4^5 = 1024 = 10 mod 13; ops 3+8+2 = 13; latency 13*4+9 = 61
   task automatic test_basic();
      run_op("basic_4_5", 8'd4, 8'd5, 3, 8'd10, 13, 61, -1);
   endtask

   task automatic test_exp_zero();
      run_op("exp_zero", 8'd7, 8'd0, 3, 8'd1, 11, 53, -1);
   endtask

   task automatic test_base_zero();
      run_op("base_zero", 8'd0, 8'd3, 3, 8'd0, 13, 61, -1);
   endtask

   // 2^255 = 2^(12*21+3) = 8 mod 13; ops 19
   task automatic test_latency();
      run_op("lat1_2_255", 8'd2, 8'd255, 1, 8'd8, 19, 47, -1);
      run_op("lat7_2_255", 8'd2, 8'd255, 7, 8'd8, 19, 161, -1);
   endtask

   task automatic test_back_to_back();
      run_op("midstart_4_5", 8'd4, 8'd5, 3, 8'd10, 13, 61, 10);
      run_op("follow_3_3", 8'd3, 8'd3, 3, 8'd1, 13, 61, -1);
   endtask

   task automatic test_idle_done();
      int s0;
      s0 = starts_total;
      for (int i = 0; i < 6; i++) begin
         inj_done = (i % 2 == 0);
         @(posedge clk_in); #1;
         checks++;
         if (mul_start_out !== 1'b0 || busy_out !== 1'b0 || done_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_done cycle %0d: start=%b busy=%b done=%b, required 0", i,
                     mul_start_out, busy_out, done_out);
         end
      end
      inj_done = 1'b0;
      checks++;
      if (result_out !== 8'd1) begin
         errors++;
         $display("FAIL idle_done result held: got %0d, required 1", result_out);
      end
      checks++;
      if (starts_total != s0) begin
         errors++;
         $display("FAIL idle_done op count: got %0d, required 0", starts_total - s0);
      end
   endtask

   task automatic test_reset_mid();
      int s0, d0, n;
      lat = 3;
      s0 = starts_total;
      base_in  = 8'd4;
      exp_in   = 8'd5;
      start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      n = 0;
      while (starts_total - s0 < 5 && n < 500) begin
         @(posedge clk_in); #1;
         n++;
      end
      checks++;
      if (starts_total - s0 != 5) begin
         errors++;
         $display("FAIL reset_mid reach op5: got %0d ops, required 5", starts_total - s0);
      end
      rst_in = 1'b1;
      @(posedge clk_in); #1;
      rst_in   = 1'b0;
      inj_done = 1'b1;
      check_idle_outputs("reset_mid_outputs");
      d0 = dones_total;
      s0 = starts_total;
      @(posedge clk_in); #1;
      inj_done = 1'b0;
      repeat (10) @(posedge clk_in);
      #1;
      check_idle_outputs("reset_mid_stale_done");
      checks++;
      if (dones_total != d0 || starts_total != s0) begin
         errors++;
         $display("FAIL reset_mid activity: dones=%0d ops=%0d, required 0 and 0",
                  dones_total - d0, starts_total - s0);
      end
      run_op("after_reset_4_5", 8'd4, 8'd5, 3, 8'd10, 13, 61, -1);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_exp_zero();
      test_base_zero();
      test_latency();
      test_back_to_back();
      test_idle_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
